// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase encoding, lamp patterns and phase durations for the intersection sequencer
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR1   = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR2   = 3'd5,
        NIGHT = 3'd6
    } phase_t;

    // Lamp bit order is {red, yellow, green}
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic logic [6:0] phase_dur(
        input phase_t s,
        input int     g_ns,
        input int     g_ew,
        input int     t_y,
        input int     t_ar
    );
        case (s)
            NS_G:       return 7'(g_ns);
            EW_G:       return 7'(g_ew);
            NS_Y, EW_Y: return 7'(t_y);
            AR1, AR2:   return 7'(t_ar);
            default:    return 7'd0;
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t s);
        case (s)
            NS_G:    return NS_Y;
            NS_Y:    return AR1;
            AR1:     return EW_G;
            EW_G:    return EW_Y;
            EW_Y:    return AR2;
            default: return NS_G;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-way intersection phase sequencer with pedestrian shortening and night flash
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int G_NS  = 30,
    parameter int G_EW  = 25,
    parameter int T_Y   = 3,
    parameter int T_AR  = 2,
    parameter int MIN_G = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_last,
    input  logic       sec_pre_last,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic       cnt_en,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [6:0] remain,
    output logic       change_soon,
    output logic       ped_walk
);

    phase_t     state;
    phase_t     state_nx;
    phase_t     succ;
    logic [6:0] remain_nx;
    logic       lit;
    logic       lit_nx;
    logic       ped_pend;
    logic       ped_pend_nx;
    logic [2:0] ns_nx;
    logic [2:0] ew_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= AR2;
            remain <= 7'(T_AR);
            lit    <= 1'b1;
        end else begin
            state  <= state_nx;
            remain <= remain_nx;
            lit    <= lit_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        remain_nx = remain;
        lit_nx    = lit;
        succ      = next_phase(state);
        if (sec_last) begin
            if (state == NIGHT) begin
                if (!night_mode) begin
                    state_nx  = AR2;
                    remain_nx = 7'(T_AR);
                end else begin
                    lit_nx = ~lit;
                end
            end else if (remain == 7'd1) begin
                // Night mode is only honoured at the end of an all-red phase
                if ((state == AR1 || state == AR2) && night_mode) begin
                    state_nx  = NIGHT;
                    remain_nx = 7'd0;
                    lit_nx    = 1'b1;
                end else begin
                    state_nx  = succ;
                    remain_nx = phase_dur(succ, G_NS, G_EW, T_Y, T_AR);
                end
            end else if (state == NS_G && ped_pend && remain > 7'(MIN_G)) begin
                remain_nx = 7'(MIN_G);
            end else begin
                remain_nx = remain - 7'd1;
            end
        end
    end

    always_comb begin
        ns_nx = LAMP_R;
        ew_nx = LAMP_R;
        case (state_nx)
            NS_G:  ns_nx = LAMP_G;
            NS_Y:  ns_nx = LAMP_Y;
            EW_G:  ew_nx = LAMP_G;
            EW_Y:  ew_nx = LAMP_Y;
            NIGHT: begin
                ns_nx = lit_nx ? LAMP_Y : LAMP_OFF;
                ew_nx = lit_nx ? LAMP_Y : LAMP_OFF;
            end
            default: ;
        endcase
    end

    // Entering EW_G serves the pending request, so the clear beats a same-cycle press
    assign ped_pend_nx = (state_nx == EW_G && state != EW_G) ? 1'b0 : (ped_pend | ped_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            ns_light <= LAMP_R;
            ew_light <= LAMP_R;
        end else begin
            ns_light <= ns_nx;
            ew_light <= ew_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_en      <= 1'b0;
            change_soon <= 1'b0;
            ped_walk    <= 1'b0;
            ped_pend    <= 1'b0;
        end else begin
            cnt_en      <= 1'b1;
            change_soon <= (remain == 7'd1) && sec_pre_last && (state != NIGHT);
            ped_walk    <= (state_nx == EW_G);
            ped_pend    <= ped_pend_nx;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

    localparam int G_NS  = 30;
    localparam int G_EW  = 25;
    localparam int T_Y   = 3;
    localparam int T_AR  = 2;
    localparam int MIN_G = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_last;
    logic       sec_pre_last;
    logic       ped_req;
    logic       night_mode;
    logic       cnt_en;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [6:0] remain;
    logic       change_soon;
    logic       ped_walk;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    // Phase index 0..5 follows the normal cycle NS_G..AR2; 6 is night flash
    int m_ph   = 5;
    int m_rem  = T_AR;
    bit m_ped  = 1'b0;
    bit m_lit  = 1'b1;
    bit m_cs   = 1'b0;
    bit m_en   = 1'b0;
    int dur_tab [6] = '{G_NS, T_Y, T_AR, G_EW, T_Y, T_AR};
    int ns_tab  [7] = '{1, 2, 4, 4, 4, 4, 2};
    int ew_tab  [7] = '{4, 4, 4, 1, 2, 4, 2};

    traffic_phase_ctrl #(
        .G_NS(G_NS), .G_EW(G_EW), .T_Y(T_Y), .T_AR(T_AR), .MIN_G(MIN_G)
    ) dut (
        .clk(clk), .rst(rst), .sec_last(sec_last), .sec_pre_last(sec_pre_last),
        .ped_req(ped_req), .night_mode(night_mode), .cnt_en(cnt_en),
        .ns_light(ns_light), .ew_light(ew_light), .remain(remain),
        .change_soon(change_soon), .ped_walk(ped_walk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit nxt_ped;
        if (rst) begin
            m_ph = 5; m_rem = T_AR; m_ped = 1'b0; m_lit = 1'b1; m_cs = 1'b0; m_en = 1'b0;
        end else begin
            m_en    = 1'b1;
            m_cs    = (m_rem == 1) && sec_pre_last && (m_ph != 6);
            nxt_ped = m_ped | ped_req;
            if (sec_last) begin
                if (m_ph == 6) begin
                    if (!night_mode) begin m_ph = 5; m_rem = T_AR; end
                    else m_lit = !m_lit;
                end else if (m_rem == 1) begin
                    if ((m_ph == 2 || m_ph == 5) && night_mode) begin
                        m_ph = 6; m_rem = 0; m_lit = 1'b1;
                    end else begin
                        m_ph  = (m_ph + 1) % 6;
                        m_rem = dur_tab[m_ph];
                        if (m_ph == 3) nxt_ped = 1'b0;
                    end
                end else if (m_ph == 0 && m_ped && m_rem > MIN_G) begin
                    m_rem = MIN_G;
                end else begin
                    m_rem = m_rem - 1;
                end
            end
            m_ped = nxt_ped;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (started) begin
            chk("ns_light",    int'(ns_light),    (m_ph == 6 && !m_lit) ? 0 : ns_tab[m_ph]);
            chk("ew_light",    int'(ew_light),    (m_ph == 6 && !m_lit) ? 0 : ew_tab[m_ph]);
            chk("remain",      int'(remain),      m_rem);
            chk("change_soon", int'(change_soon), int'(m_cs));
            chk("ped_walk",    int'(ped_walk),    int'(m_ph == 3));
            chk("cnt_en",      int'(cnt_en),      int'(m_en));
        end
    end

    task automatic cyc(input bit l, input bit pl, input bit pr);
        sec_last = l; sec_pre_last = pl; ped_req = pr;
        @(posedge clk);
        #2;
    endtask

    task automatic second(input bit pr_pre);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, pr_pre);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; sec_last = 1'b0; sec_pre_last = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
        @(posedge clk); #2;
        started = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_remain", int'(remain), 2);
        chk("rst_ns", int'(ns_light), 4);
        chk("rst_ew", int'(ew_light), 4);
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_walk", int'(ped_walk), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("cnt_en_after_rst", int'(cnt_en), 1);

        repeat (2) second(1'b0);
        chk("first_nsg_remain", int'(remain), 30);
        chk("first_nsg_ns", int'(ns_light), 1);
        chk("first_nsg_ew", int'(ew_light), 4);

        repeat (30) second(1'b0);
        chk("nsy_ns", int'(ns_light), 2);
        chk("nsy_remain", int'(remain), 3);
        repeat (35) second(1'b0);
        chk("cycle_back_ns", int'(ns_light), 1);
        chk("cycle_back_remain", int'(remain), 30);

        repeat (10) second(1'b0);
        chk("before_ped_remain", int'(remain), 20);
        second(1'b1);
        chk("ped_short_remain", int'(remain), 5);
        repeat (4) second(1'b0);
        chk("ped_short_last", int'(remain), 1);
        second(1'b0);
        chk("ped_short_nsy", int'(ns_light), 2);
        repeat (5) second(1'b0);
        chk("ewg_walk", int'(ped_walk), 1);
        chk("ewg_ew", int'(ew_light), 1);
        repeat (30) second(1'b0);
        repeat (26) second(1'b0);
        chk("late_ped_before", int'(remain), 4);
        second(1'b1);
        chk("late_ped_no_short", int'(remain), 3);
        repeat (2) second(1'b0);
        second(1'b1);
        chk("pre_last_ped_nsy_ns", int'(ns_light), 2);
        chk("pre_last_ped_nsy_remain", int'(remain), 3);

        repeat (5) second(1'b0);
        night_mode = 1'b1;
        repeat (28) second(1'b0);
        chk("pre_night_ar2", int'(remain), 2);
        repeat (2) second(1'b0);
        chk("night_ns", int'(ns_light), 2);
        chk("night_ew", int'(ew_light), 2);
        chk("night_remain", int'(remain), 0);
        second(1'b0);
        chk("night_off_ns", int'(ns_light), 0);
        second(1'b0);
        chk("night_on_ew", int'(ew_light), 2);
        night_mode = 1'b0;
        second(1'b0);
        chk("night_exit_ns", int'(ns_light), 4);
        chk("night_exit_remain", int'(remain), 2);

        repeat (2) second(1'b0);
        second(1'b0);
        chk("ped_cleared_at_ewg", int'(remain), 29);
        repeat (34) second(1'b0);
        repeat (15) second(1'b0);
        chk("mid_ewg_remain", int'(remain), 10);
        cyc(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("midrst_remain", int'(remain), 2);
        chk("midrst_ns", int'(ns_light), 4);
        chk("midrst_ew", int'(ew_light), 4);
        chk("midrst_cnt_en", int'(cnt_en), 0);
        chk("midrst_walk", int'(ped_walk), 0);
        repeat (3) second(1'b0);
        chk("midrst_ped_cleared", int'(remain), 29);

        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("pre_last_alone", int'(remain), 29);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
